// File: rtl/alu_cmd_queue.sv
// Command FIFO plus result register in front of the 4-bit ALU core.
// The head command drives the ALU combinationally; its result is captured when the output slot is free.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  output logic [2:0]               alu_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  input  logic [3:0]               alu_r,
  input  logic                     alu_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_r,
  output logic                     out_ovf,
  output logic                     out_err,
  output logic [2:0]               out_op,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          push;
  logic          cap;
  logic          head_illegal;
  logic          head_arith;
  logic [3:0]    cap_r;
  logic          cap_ovf;

  // in_ready depends only on registered level, never on out_ready.
  assign in_ready = (level != FULL_LEVEL);
  assign empty    = (level == '0);
  assign push     = in_valid && in_ready;
  assign cap      = !empty && (!out_valid || out_ready);

  assign head         = mem[rd_ptr];
  assign head_illegal = (head.op > 3'b100);
  assign head_arith   = (head.op[2:1] == 2'b00);

  always_comb begin
    alu_op = 3'b000;
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    if (!empty) begin
      alu_op = head.op;
      alu_a  = head.a;
      alu_b  = head.b;
    end
  end

  // The ALU keeps a stale overflow flag on logic ops, so only arithmetic ops may pass it.
  always_comb begin
    cap_r   = head_illegal ? 4'h0 : alu_r;
    cap_ovf = head_arith ? alu_ovf : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (cap) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, cap})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= 4'h0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      out_op    <= 3'b000;
      err_count <= 8'h00;
    end else begin
      if (cap) begin
        out_valid <= 1'b1;
        out_r     <= cap_r;
        out_ovf   <= cap_ovf;
        out_err   <= head_illegal;
        out_op    <= head.op;
        if (head_illegal && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'h01;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
